uart_like_transmit: RTL and testbench

- Serial frame transmitter, the send side of the team's single-wire serial link.
- Accepts 8-bit words over a valid/ready handshake and buffers one word.
- Serializes each word on txd as: start bit (0), 8 data bits MSB first, stop bit(s) (1). Line idles high.
- Back-to-back words go out with no idle gap between frames.

---
 rtl/uart_like_transmit_if.sv | 18 +
 rtl/uart_like_transmit.sv | 132 +++++++++++++
 tb/tb_uart_like_transmit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_like_transmit_if.sv
// Word handshake between a word source and the serial frame transmitter.
interface uart_like_transmit_if;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;

  modport master (
    output word,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/uart_like_transmit.sv
// Serial frame transmitter: start bit, 8 data bits MSB first, stop bit(s); line idles high.
// One word of buffering lets frames go out back to back with no idle gap.
module uart_like_transmit #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_like_transmit_if.slave   bus,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned     BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [7:0]       hold_q;
  logic [7:0]       shift_q;
  logic             hold_full_q;
  logic             ready_q;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;

  logic accept;
  logic bit_end;

  assign accept  = bus.word_valid & ready_q;
  assign bit_end = (baud_q == BaudLast);

  assign bus.word_ready = ready_q;
  assign txd            = txd_q;
  assign busy           = busy_q;
  assign done           = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // Accept and holding-register transfer never coincide: ready is low while full.
      if (accept) begin
        hold_q      <= bus.word;
        hold_full_q <= 1'b1;
        ready_q     <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            txd_q       <= 1'b0;
            busy_q      <= 1'b1;
            baud_q      <= '0;
            state_q     <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[7];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= StStop;
            end else begin
              shift_q <= {shift_q[6:0], 1'b0};
              txd_q   <= shift_q[6];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == StopLast) begin
              bit_q  <= '0;
              done_q <= 1'b1;
              // A queued word starts its frame immediately after the last stop bit.
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                ready_q     <= 1'b1;
                txd_q       <= 1'b0;
                state_q     <= StStart;
              end else begin
                txd_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_like_transmit.sv
// Directed bench for uart_like_transmit: one-clock-per-bit instance driven from a vector
// table, plus a 4-clocks-per-bit, 2-stop-bit instance and reset/backpressure sequences.
module tb_uart_like_transmit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_like_transmit_if if1 ();
  uart_like_transmit_if if2 ();

  logic txd1, busy1, done1;
  logic txd2, busy2, done2;

  uart_like_transmit #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if1),
    .txd  (txd1),
    .busy (busy1),
    .done (done1)
  );

  uart_like_transmit #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if2),
    .txd  (txd2),
    .busy (busy2),
    .done (done2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0][7:0] w;
    int              n;
    logic [29:0]     exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Sends n words on dut1 with valid held until each is taken, checking every cycle.
  task automatic run_stream(input logic [2:0][7:0] w, input int n, input logic [29:0] exp);
    int   idx;
    logic rdy;
    logic exp_rdy;
    @(negedge clk);
    chk("idle_ready", {31'd0, if1.word_ready}, 32'd1);
    if1.word       = w[0];
    if1.word_valid = 1'b1;
    @(posedge clk);
    idx = 1;
    #1;
    if (idx < n) if1.word = w[idx];
    else if1.word_valid = 1'b0;
    chk("ready_after_accept", {31'd0, if1.word_ready}, 32'd0);
    rdy = if1.word_ready;
    for (int i = 0; i <= 10 * n; i++) begin
      @(posedge clk);
      if (if1.word_valid && rdy) idx++;
      #1;
      if (idx < n) if1.word = w[idx];
      else if1.word_valid = 1'b0;
      rdy     = if1.word_ready;
      exp_rdy = !((n >= 2 && i >= 1 && i <= 9) || (n >= 3 && i >= 11 && i <= 19));
      chk("txd", {31'd0, txd1}, {31'd0, (i < 10 * n) ? exp[29 - i] : 1'b1});
      chk("busy", {31'd0, busy1}, {31'd0, i < 10 * n});
      chk("done", {31'd0, done1}, {31'd0, i > 0 && (i % 10) == 0});
      chk("word_ready", {31'd0, if1.word_ready}, {31'd0, exp_rdy});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Frames: A5=0_10100101_1, 3C=0_00111100_1, 11=0_00010001_1, 00, FF, 0F.
    vecs[0] = '{w: {8'h00, 8'h00, 8'hA5}, n: 1, exp: {10'b0101001011, 20'b0}};
    vecs[1] = '{w: {8'h00, 8'h00, 8'h00}, n: 1, exp: {10'b0000000001, 20'b0}};
    vecs[2] = '{w: {8'h00, 8'h00, 8'hFF}, n: 1, exp: {10'b0111111111, 20'b0}};
    vecs[3] = '{w: {8'h00, 8'h3C, 8'hA5}, n: 2, exp: {10'b0101001011, 10'b0001111001, 10'b0}};
    vecs[4] = '{w: {8'h11, 8'h3C, 8'hA5}, n: 3,
                exp: {10'b0101001011, 10'b0001111001, 10'b0000100011}};

    rst            = 1'b1;
    if1.word       = '0;
    if1.word_valid = 1'b0;
    if2.word       = '0;
    if2.word_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd1", {31'd0, txd1}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_ready1", {31'd0, if1.word_ready}, 32'd1);
    chk("rst_txd2", {31'd0, txd2}, 32'd1);
    chk("rst_ready2", {31'd0, if2.word_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_stream(vecs[v].w, vecs[v].n, vecs[v].exp);
      repeat (2) @(posedge clk);
    end

    // Reset in the middle of the data bits of 0xFF abandons the frame.
    @(negedge clk);
    if1.word       = 8'hFF;
    if1.word_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.word_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy1}, 32'd1);
    chk("pre_rst_txd", {31'd0, txd1}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_txd", {31'd0, txd1}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rst_ready", {31'd0, if1.word_ready}, 32'd1);
    chk("mid_rst_done", {31'd0, done1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_done", {31'd0, done1}, 32'd0);
      chk("post_rst_txd", {31'd0, txd1}, 32'd1);
    end
    run_stream({8'h00, 8'h00, 8'h0F}, 1, {10'b0000011111, 20'b0});

    // 4 clocks per bit, 2 stop bits, 0x80: 4 low, 4 high, 28 low, 8 high.
    @(negedge clk);
    if2.word       = 8'h80;
    if2.word_valid = 1'b1;
    @(posedge clk);
    #1;
    if2.word_valid = 1'b0;
    for (int i = 0; i <= 44; i++) begin
      @(posedge clk);
      #1;
      chk("txd2", {31'd0, txd2},
          {31'd0, (i >= 4 && i < 8) || i >= 36});
      chk("busy2", {31'd0, busy2}, {31'd0, i < 44});
      chk("done2", {31'd0, done2}, {31'd0, i == 44});
    end
    @(posedge clk);
    #1;
    chk("done2_once", {31'd0, done2}, 32'd0);
    chk("idle2_ready", {31'd0, if2.word_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
